// File: rtl/adder_share_ctrl_pkg.sv
// Shared types and constants for the time-shared slice adder.
// State encoding, slice width and the round-robin pick helper.
package adder_share_ctrl_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Pick the requester id: the preferred one when both ask,
    // otherwise whichever is asking.
    function automatic logic rr_pick(input logic [1:0] v, input logic pri);
        logic id;
        id = v[1];
        if (v[0] && v[1]) begin
            id = pri;
        end
        return id;
    endfunction

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Request/response bundle between the two requesters,
// the result consumer and the shared adder controller.
interface adder_share_ctrl_if #(
    parameter int WIDTH = 64
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;

    modport master (
        output req_valid, req0_a, req0_b, req1_a, req1_b, req_cin,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req1_a, req1_b, req_cin,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/adder_share_ctrl_adder8.sv
// Single 8-bit ripple adder slice: the only arithmetic
// resource, reused once per slice of every operation.
module adder_share_ctrl_adder8
    import adder_share_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               ci_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               co_o
);

    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i}
                       + {{SLICE_W{1'b0}}, ci_i};

endmodule

// File: rtl/adder_share_ctrl.sv
// Two-requester adder that time-shares one 8-bit slice adder,
// LSB slice first, with round-robin grant and held response.
module adder_share_ctrl
    import adder_share_ctrl_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int SLICES = WIDTH / SLICE_W
) (
    input logic               clk,
    input logic               rst_n,
    adder_share_ctrl_if.slave bus
);

    localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             pri_q, pri_d;
    logic             id_q, id_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;

    logic             gnt_id;
    logic [1:0]       ready;
    logic             accept;
    int               sel;
    logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
    logic             sl_co;

    assign gnt_id = rr_pick(bus.req_valid, pri_q);
    assign ready  = (state_q == IDLE && rst_n && |bus.req_valid)
                  ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign accept = |(bus.req_valid & ready);

    assign sel  = SLICE_W * int'(cnt_q);
    assign sl_a = a_q[sel +: SLICE_W];
    assign sl_b = b_q[sel +: SLICE_W];

    adder_share_ctrl_adder8 u_adder8 (
        .a_i  (sl_a),
        .b_i  (sl_b),
        .ci_i (carry_q),
        .s_o  (sl_s),
        .co_o (sl_co)
    );

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;

    // Control state: FSM, slice counter, carry and rr pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            pri_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            pri_q   <= pri_d;
        end
    end

    // Datapath: latched operands and the response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q   <= 1'b0;
            cout_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
        end else begin
            id_q   <= id_d;
            cout_q <= cout_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sum_q  <= sum_d;
        end
    end

    // Next state: accept in IDLE, one slice per RUN cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        pri_d   = pri_q;
        id_d    = id_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = gnt_id ? bus.req1_a : bus.req0_a;
                    b_d     = gnt_id ? bus.req1_b : bus.req0_b;
                    carry_d = bus.req_cin[gnt_id];
                    id_d    = gnt_id;
                    pri_d   = ~gnt_id;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[sel +: SLICE_W] = sl_s;
                carry_d = sl_co;
                if (cnt_q == LAST) begin
                    cout_d  = sl_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/adder_share_ctrl.md
ADDER_SHARE_CTRL -- requirements
Module: adder_share_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning operand width in bits; it must be a multiple of 8 and at least 8.
REQ-002 The block SHALL have parameter SLICES, default WIDTH/8, meaning the number of 8-bit passes per operation.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port req_valid, input, 2 bits: per-requester operation request.
REQ-006 Port req_ready, output, 2 bits: per-requester accept; one-hot or zero.
REQ-007 Port req0_a, req0_b, input, WIDTH bits each: requester-0 operands.
REQ-008 Port req1_a, req1_b, input, WIDTH bits each: requester-1 operands.
REQ-009 Port req_cin, input, 2 bits: per-requester carry-in.
REQ-010 Port rsp_valid, output, 1 bit: result available.
REQ-011 Port rsp_ready, input, 1 bit: result consumer accept.
REQ-012 Port rsp_id, output, 1 bit: index of the requester that owns the result.
REQ-013 Port rsp_sum, output, WIDTH bits: sum.
REQ-014 Port rsp_cout, output, 1 bit: carry-out of the MSB.

Function
REQ-015 The block SHALL time-share one 8-bit ripple adder among both requesters, computing a+b+cin over SLICES cycles, LSB slice first.
REQ-016 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-017 In IDLE, req_ready SHALL be asserted combinationally, only for the round-robin grant among the asserted req_valid bits; it SHALL be 0 in RUN and DONE.
REQ-018 Round-robin pointer: a grant SHALL go to the requester other than the last served when both are valid; after reset, requester 0 has priority.
REQ-019 A handshake (req_valid[i] & req_ready[i]) in cycle T SHALL latch the operands and cin, record the id, clear the slice counter and enter RUN.
REQ-020 RUN SHALL cover cycles T+1..T+SLICES; in each cycle, slice k=counter SHALL be added with the registered carry and the result written to sum[8k+7:8k]; the slice carry-out SHALL be registered as the next carry-in.
REQ-021 After slice SLICES-1, the block SHALL enter DONE; rsp_valid SHALL be 1 from cycle T+SLICES+1, with rsp_cout equal to the final carry.
REQ-022 rsp_valid, rsp_id, rsp_sum and rsp_cout SHALL hold stable while rsp_valid & !rsp_ready.
REQ-023 rsp_valid & rsp_ready SHALL return the block to IDLE in the next cycle; a new grant is possible in that IDLE cycle, giving a minimum issue interval of SLICES+2 cycles.
REQ-024 Changes to req_* inputs during RUN or DONE SHALL NOT affect the result in flight.
REQ-025 The arithmetic SHALL be modulo 2^WIDTH with a separate cout; there are no signed semantics.
REQ-026 The slice counter SHALL be $clog2(SLICES) bits and SHALL NOT wrap inside RUN; it is cleared on every accept.
REQ-027 If neither requester is valid in IDLE, the block SHALL remain in IDLE with req_ready=0.

Reset
REQ-028 When rst_n=0 at a clock edge, the block SHALL go to IDLE and clear the counter, carry, rr pointer (requester 0 first), rsp_valid, rsp_id, rsp_sum and rsp_cout; req_ready SHALL be 0 during reset.
REQ-029 A reset during RUN or DONE SHALL abort the operation with no response; the aborted requester must re-request.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=0, RUN=1, DONE=2) and the slice width constant (8).
REQ-031 The block SHALL instantiate one adder8 sub-module as the only arithmetic resource; muxing selects the operand slice by counter.

Verification
REQ-032 Reset, req0 a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> rsp_valid at T+9, sum=0, cout=1, id=0.
REQ-033 Both requesters valid at once, req0 a=5,b=7, req1 a=100,b=28 -> first rsp_id=0 sum=12, then id=1 sum=128, with the req1 accept exactly 1 cycle after the first rsp handshake.
REQ-034 rsp_ready held low for 5 cycles in DONE -> outputs stable, req_ready=0 throughout, no second accept.
REQ-035 Operands changed in the cycle after accept (a=1,b=1 then a=9) -> sum=2.
REQ-036 rst_n=0 at RUN slice 3 -> next cycle rsp_valid=0 and state IDLE; a subsequent req1 a=0x80,b=0x80,cin=1 -> sum=0x101, cout=0.
REQ-037 Random 1000 operations with random valid/ready -> every result equals a+b+cin in {cout,sum}, and both requesters are served fairly.
